busca_menor_ctrl: RTL and testbench

- Sequencer for the open-node minimum-cost search in the shortest-path engine.
- Sweeps the node-cost memory one batch of NUM_COMPARADOR lanes per cycle into the external running-minimum comparator (comparador_na), masking closed nodes.
- Tracks which batch produced the minimum, re-reads that batch, and priority-encodes the winning node index. Reports {found, cost, node} to the main FSM with a start/done handshake.

---
 rtl/busca_menor_pkg.sv | 27 ++
 rtl/prio_lane_enc.sv | 23 ++
 rtl/busca_menor_ctrl.sv | 160 ++++++++++++++++
 tb/tb_busca_menor_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/busca_menor_pkg.sv
// Shared definitions for the open-node minimum-cost search sequencer:
// FSM state encoding, cost-infinity constant and a width helper.
package busca_menor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_SCAN   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_REREAD = 3'd4,
      ST_MATCH  = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   localparam int DEF_DATA_WIDTH = 8;
   localparam logic [DEF_DATA_WIDTH-1:0] COST_INF = '1;

   // Never returns 0 so that single-entry configurations still get a 1-bit bus.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/prio_lane_enc.sv
// Combinational lowest-index-first priority encoder over the per-lane match
// bits of one batch; hit is low when no lane matches.
module prio_lane_enc #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] match,
   output logic [W-1:0] lane,
   output logic         hit
);

   always_comb begin
      lane = '0;
      hit  = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (match[i]) begin
            lane = W'(i);
            hit  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/busca_menor_ctrl.sv
// Open-node minimum-cost search sequencer: sweeps cost memory into the external
// running-minimum comparator, then re-reads the winning batch to find the node.
// Optional macro BUSCA_MENOR_ABORT_EN adds abort_in to cancel a search.
module busca_menor_ctrl
   import busca_menor_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_COMPARADOR = 8,
   parameter int NUM_BATCH      = 16,
   parameter int ADDR_WIDTH     = clog2(NUM_BATCH),
   parameter int NODE_WIDTH     = clog2(NUM_BATCH * NUM_COMPARADOR)
) (
   input  logic                                 clk,
   input  logic                                 rst,
`ifdef BUSCA_MENOR_ABORT_EN
   input  logic                                 abort_in,
`endif
   input  logic                                 start_in,
   output logic                                 busy_out,
   output logic                                 done_out,
   output logic                                 found_out,
   output logic [DATA_WIDTH-1:0]                min_cost_out,
   output logic [NODE_WIDTH-1:0]                min_node_out,
   output logic                                 mem_rd_out,
   output logic [ADDR_WIDTH-1:0]                mem_addr_out,
   input  logic [DATA_WIDTH*NUM_COMPARADOR-1:0] mem_data_in,
   input  logic [NUM_COMPARADOR-1:0]            mem_open_in,
   output logic                                 comp_iniciar_out,
   output logic                                 comp_atualizar_out,
   output logic [DATA_WIDTH*NUM_COMPARADOR-1:0] comp_data_out,
   input  logic [DATA_WIDTH-1:0]                comp_min_in
);

   localparam int LANE_WIDTH = clog2(NUM_COMPARADOR);
   localparam logic [DATA_WIDTH-1:0] INF = '1;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   scan_cnt;
   logic                    drain_last;
   logic [ADDR_WIDTH-1:0]   best_batch;
   logic [ADDR_WIDTH-1:0]   idx_d1, idx_d2;
   logic [DATA_WIDTH-1:0]   prev_min;
   logic                    ret_valid;
   logic                    abort_req;
   logic [NUM_COMPARADOR-1:0] match;
   logic [LANE_WIDTH-1:0]   win_lane;
   logic                    win_hit;
   logic [NODE_WIDTH-1:0]   win_node;

`ifdef BUSCA_MENOR_ABORT_EN
   assign abort_req = abort_in;
`else
   assign abort_req = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start_in) state_nxt = ST_INIT;
         ST_INIT:   state_nxt = ST_SCAN;
         ST_SCAN:   if (scan_cnt == ADDR_WIDTH'(NUM_BATCH - 1)) state_nxt = ST_DRAIN;
         ST_DRAIN:  if (drain_last) state_nxt = ST_REREAD;
         ST_REREAD: state_nxt = ST_MATCH;
         ST_MATCH:  state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      // Cancel wins over every transition, including leaving DONE.
      if (abort_req && (state != ST_IDLE)) state_nxt = ST_IDLE;
   end

   always_comb begin
      busy_out           = (state != ST_IDLE);
      done_out           = (state == ST_DONE);
      comp_iniciar_out   = (state == ST_INIT);
      mem_rd_out         = (state == ST_SCAN) || (state == ST_REREAD);
      comp_atualizar_out = ret_valid;
      mem_addr_out       = '0;
      if (state == ST_SCAN)   mem_addr_out = scan_cnt;
      if (state == ST_REREAD) mem_addr_out = best_batch;
   end

   // Closed lanes and non-scan cycles present infinity to the comparator.
   always_comb begin
      comp_data_out = '1;
      for (int i = 0; i < NUM_COMPARADOR; i++) begin
         if (ret_valid && mem_open_in[i])
            comp_data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_COMPARADOR; i++) begin
         match[i] = mem_open_in[i] && (comp_min_in != INF) &&
                    (mem_data_in[i*DATA_WIDTH +: DATA_WIDTH] == comp_min_in);
      end
   end

   prio_lane_enc #(
      .N (NUM_COMPARADOR),
      .W (LANE_WIDTH)
   ) u_enc (
      .match (match),
      .lane  (win_lane),
      .hit   (win_hit)
   );

   assign win_node = NODE_WIDTH'(best_batch) * NODE_WIDTH'(NUM_COMPARADOR) + NODE_WIDTH'(win_lane);

   // comp_min_in trails the address by two cycles, so the batch index does too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt   <= '0;
         drain_last <= 1'b0;
         best_batch <= '0;
         idx_d1     <= '0;
         idx_d2     <= '0;
         prev_min   <= INF;
         ret_valid  <= 1'b0;
      end else begin
         idx_d1    <= mem_addr_out;
         idx_d2    <= idx_d1;
         ret_valid <= (state == ST_SCAN) && !abort_req;
         case (state)
            ST_INIT: begin
               scan_cnt   <= '0;
               drain_last <= 1'b0;
               best_batch <= '0;
               prev_min   <= INF;
            end
            ST_SCAN, ST_DRAIN: begin
               if (state == ST_SCAN) scan_cnt <= scan_cnt + ADDR_WIDTH'(1);
               else                  drain_last <= 1'b1;
               prev_min <= comp_min_in;
               if (comp_min_in < prev_min) best_batch <= idx_d2;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         found_out    <= 1'b0;
         min_cost_out <= INF;
         min_node_out <= '0;
      end else if ((state == ST_MATCH) && !abort_req) begin
         found_out    <= win_hit;
         min_cost_out <= win_hit ? comp_min_in : INF;
         min_node_out <= win_hit ? win_node : '0;
      end
   end

endmodule

// File: tb/tb_busca_menor_ctrl.sv
// Directed bench for busca_menor_ctrl with a cost-memory model and a
// running-minimum comparator model; abort scenario under BUSCA_MENOR_ABORT_EN.
`timescale 1ns/1ps
module tb_busca_menor_ctrl;

   localparam int DW = 8;
   localparam int NC = 8;
   localparam int NB = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_in;
   logic          abort_in;
   logic          busy_out, done_out, found_out;
   logic [7:0]    min_cost_out;
   logic [6:0]    min_node_out;
   logic          mem_rd_out;
   logic [3:0]    mem_addr_out;
   logic [63:0]   mem_data_in = '0;
   logic [7:0]    mem_open_in = '0;
   logic          comp_iniciar_out, comp_atualizar_out;
   logic [63:0]   comp_data_out;
   logic [7:0]    comp_min_in;

   logic [7:0]    cost_mem [NB*NC];
   logic          open_mem [NB*NC];

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   busca_menor_ctrl dut (
      .clk                (clk),
      .rst                (rst),
`ifdef BUSCA_MENOR_ABORT_EN
      .abort_in           (abort_in),
`endif
      .start_in           (start_in),
      .busy_out           (busy_out),
      .done_out           (done_out),
      .found_out          (found_out),
      .min_cost_out       (min_cost_out),
      .min_node_out       (min_node_out),
      .mem_rd_out         (mem_rd_out),
      .mem_addr_out       (mem_addr_out),
      .mem_data_in        (mem_data_in),
      .mem_open_in        (mem_open_in),
      .comp_iniciar_out   (comp_iniciar_out),
      .comp_atualizar_out (comp_atualizar_out),
      .comp_data_out      (comp_data_out),
      .comp_min_in        (comp_min_in)
   );

   // Cost memory: one-cycle read latency.
   always @(posedge clk) begin
      if (mem_rd_out) begin
         for (int i = 0; i < NC; i++) begin
            mem_data_in[8*i +: 8] <= cost_mem[int'(mem_addr_out)*NC + i];
            mem_open_in[i]        <= open_mem[int'(mem_addr_out)*NC + i];
         end
      end
   end

   function automatic logic [7:0] batch_min(input logic [7:0] cur, input logic [63:0] d);
      logic [7:0] m;
      m = cur;
      for (int i = 0; i < NC; i++) if (d[8*i +: 8] < m) m = d[8*i +: 8];
      return m;
   endfunction

   // Running-minimum comparator: registered output.
   always @(posedge clk or posedge rst) begin
      if (rst)                     comp_min_in <= 8'hFF;
      else if (comp_iniciar_out)   comp_min_in <= 8'hFF;
      else if (comp_atualizar_out) comp_min_in <= batch_min(comp_min_in, comp_data_out);
   end

   task automatic fill(input logic open_all, input logic [7:0] cost_all);
      for (int n = 0; n < NB*NC; n++) begin
         open_mem[n] = open_all;
         cost_mem[n] = cost_all;
      end
   endtask

   // Starts a search (edge 0) and watches cycles 1..ncyc, sampling at negedge.
   task automatic run_search(input int pulse_at, input int hold_until, input int rst_at,
                             input int ncyc, output int d1, output int d2, output int np,
                             output logic busy_rst, output logic [63:0] cd3,
                             output logic [63:0] cd4);
      d1 = 0; d2 = 0; np = 0; busy_rst = 1'b1; cd3 = '0; cd4 = '0;
      @(negedge clk);
      start_in = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (done_out === 1'b1) begin
            np++;
            if (d1 == 0) d1 = k;
            else if (d2 == 0) d2 = k;
         end
         if (k == 3) cd3 = comp_data_out;
         if (k == 4) cd4 = comp_data_out;
         start_in = (k <= hold_until) || (k == pulse_at);
         rst      = (k == rst_at);
         if (k == rst_at) begin
            #1 busy_rst = busy_out;
         end
      end
      start_in = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_in = 1'b0; abort_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy_out !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy_out); else passes++;
      checks++; if (done_out !== 1'b0) $display("FAIL reset_done got %0b exp 0", done_out); else passes++;
      checks++; if (found_out !== 1'b0) $display("FAIL reset_found got %0b exp 0", found_out); else passes++;
      checks++; if (min_cost_out !== 8'hFF) $display("FAIL reset_cost got %h exp ff", min_cost_out); else passes++;
      checks++; if (min_node_out !== 7'd0) $display("FAIL reset_node got %0d exp 0", min_node_out); else passes++;
      checks++; if ({mem_rd_out, comp_iniciar_out, comp_atualizar_out} !== 3'b000)
         $display("FAIL reset_strobes got %b exp 000", {mem_rd_out, comp_iniciar_out, comp_atualizar_out}); else passes++;
      checks++; if (mem_addr_out !== 4'd0) $display("FAIL reset_addr got %0d exp 0", mem_addr_out); else passes++;
      checks++; if (comp_data_out !== {64{1'b1}}) $display("FAIL reset_cdata got %h exp all ones", comp_data_out); else passes++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_open();
      int d1, d2, np; logic b; logic [63:0] c3, c4;
      fill(1'b0, 8'h00);
      open_mem[37] = 1'b1; cost_mem[37] = 8'd5;
      run_search(0, 0, 0, 30, d1, d2, np, b, c3, c4);
      checks++; if (d1 !== 22) $display("FAIL single_done_cycle got %0d exp 22", d1); else passes++;
      checks++; if (np !== 1) $display("FAIL single_pulses got %0d exp 1", np); else passes++;
      checks++; if (found_out !== 1'b1) $display("FAIL single_found got %0b exp 1", found_out); else passes++;
      checks++; if (min_node_out !== 7'd37) $display("FAIL single_node got %0d exp 37", min_node_out); else passes++;
      checks++; if (min_cost_out !== 8'd5) $display("FAIL single_cost got %0d exp 5", min_cost_out); else passes++;
   endtask

   task automatic test_none_open();
      int d1, d2, np; logic b; logic [63:0] c3, c4;
      fill(1'b0, 8'h01);
      run_search(0, 0, 0, 30, d1, d2, np, b, c3, c4);
      checks++; if (d1 !== 22) $display("FAIL none_done_cycle got %0d exp 22", d1); else passes++;
      checks++; if (found_out !== 1'b0) $display("FAIL none_found got %0b exp 0", found_out); else passes++;
      checks++; if (min_cost_out !== 8'hFF) $display("FAIL none_cost got %h exp ff", min_cost_out); else passes++;
      checks++; if (min_node_out !== 7'd0) $display("FAIL none_node got %0d exp 0", min_node_out); else passes++;
   endtask

   task automatic test_ties();
      int d1, d2, np; logic b; logic [63:0] c3, c4;
      fill(1'b1, 8'd9);
      cost_mem[12] = 8'd3; cost_mem[13] = 8'd3; cost_mem[100] = 8'd3;
      run_search(0, 0, 0, 30, d1, d2, np, b, c3, c4);
      checks++; if (min_node_out !== 7'd12) $display("FAIL ties_node got %0d exp 12", min_node_out); else passes++;
      checks++; if (min_cost_out !== 8'd3) $display("FAIL ties_cost got %0d exp 3", min_cost_out); else passes++;
   endtask

   task automatic test_closed_mask();
      int d1, d2, np; logic b; logic [63:0] c3, c4;
      fill(1'b0, 8'h00);
      cost_mem[5] = 8'd1;
      open_mem[9] = 1'b1; cost_mem[9] = 8'd2;
      run_search(0, 0, 0, 30, d1, d2, np, b, c3, c4);
      checks++; if (c3[47:40] !== 8'hFF) $display("FAIL mask_lane5 got %h exp ff", c3[47:40]); else passes++;
      checks++; if (c4[15:8] !== 8'h02) $display("FAIL mask_lane1 got %h exp 02", c4[15:8]); else passes++;
      checks++; if (min_node_out !== 7'd9) $display("FAIL mask_node got %0d exp 9", min_node_out); else passes++;
      checks++; if (min_cost_out !== 8'd2) $display("FAIL mask_cost got %0d exp 2", min_cost_out); else passes++;
   endtask

   task automatic test_boundaries();
      int d1, d2, np; logic b; logic [63:0] c3, c4;
      fill(1'b0, 8'h00);
      open_mem[50] = 1'b1; cost_mem[50] = 8'hFF;
      run_search(0, 0, 0, 30, d1, d2, np, b, c3, c4);
      checks++; if (found_out !== 1'b0) $display("FAIL inf_open_found got %0b exp 0", found_out); else passes++;
      checks++; if (min_node_out !== 7'd0) $display("FAIL inf_open_node got %0d exp 0", min_node_out); else passes++;
      open_mem[127] = 1'b1; cost_mem[127] = 8'd0;
      run_search(0, 0, 0, 30, d1, d2, np, b, c3, c4);
      checks++; if (min_node_out !== 7'd127) $display("FAIL last_node got %0d exp 127", min_node_out); else passes++;
      checks++; if (min_cost_out !== 8'd0) $display("FAIL last_cost got %0d exp 0", min_cost_out); else passes++;
   endtask

   task automatic test_start_ignored();
      int d1, d2, np; logic b; logic [63:0] c3, c4;
      fill(1'b1, 8'd200);
      cost_mem[70] = 8'd17;
      run_search(5, 0, 0, 30, d1, d2, np, b, c3, c4);
      checks++; if (d1 !== 22) $display("FAIL ign_done_cycle got %0d exp 22", d1); else passes++;
      checks++; if (np !== 1) $display("FAIL ign_pulses got %0d exp 1", np); else passes++;
      checks++; if (min_node_out !== 7'd70) $display("FAIL ign_node got %0d exp 70", min_node_out); else passes++;
   endtask

   task automatic test_rst_mid();
      int d1, d2, np; logic b; logic [63:0] c3, c4;
      fill(1'b0, 8'h00);
      open_mem[9] = 1'b1; cost_mem[9] = 8'd2;
      run_search(0, 0, 6, 30, d1, d2, np, b, c3, c4);
      checks++; if (b !== 1'b0) $display("FAIL rst_busy got %0b exp 0", b); else passes++;
      checks++; if (np !== 0) $display("FAIL rst_pulses got %0d exp 0", np); else passes++;
      checks++; if (found_out !== 1'b0) $display("FAIL rst_found got %0b exp 0", found_out); else passes++;
      checks++; if (min_cost_out !== 8'hFF) $display("FAIL rst_cost got %h exp ff", min_cost_out); else passes++;
      run_search(0, 0, 0, 30, d1, d2, np, b, c3, c4);
      checks++; if (d1 !== 22) $display("FAIL rst_again_cycle got %0d exp 22", d1); else passes++;
      checks++; if (min_node_out !== 7'd9) $display("FAIL rst_again_node got %0d exp 9", min_node_out); else passes++;
   endtask

   task automatic test_back_to_back();
      int d1, d2, np; logic b; logic [63:0] c3, c4;
      fill(1'b1, 8'd40);
      cost_mem[88] = 8'd6;
      run_search(0, 23, 0, 50, d1, d2, np, b, c3, c4);
      checks++; if (d1 !== 22) $display("FAIL b2b_first got %0d exp 22", d1); else passes++;
      checks++; if (d2 !== 45) $display("FAIL b2b_second got %0d exp 45", d2); else passes++;
      checks++; if (np !== 2) $display("FAIL b2b_pulses got %0d exp 2", np); else passes++;
      checks++; if (min_node_out !== 7'd88) $display("FAIL b2b_node got %0d exp 88", min_node_out); else passes++;
   endtask

`ifdef BUSCA_MENOR_ABORT_EN
   task automatic test_abort();
      int np;
      fill(1'b0, 8'h00);
      open_mem[37] = 1'b1; cost_mem[37] = 8'd5;
      begin
         int d1, d2; logic b; logic [63:0] c3, c4;
         run_search(0, 0, 0, 30, d1, d2, np, b, c3, c4);
      end
      open_mem[9] = 1'b1; cost_mem[9] = 8'd2;
      np = 0;
      @(negedge clk); start_in = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start_in = 1'b0;
         if (done_out === 1'b1) np++;
         if (k == 19) begin
            checks++; if (busy_out !== 1'b0) $display("FAIL abort_busy got %0b exp 0", busy_out); else passes++;
            checks++; if (mem_rd_out !== 1'b0) $display("FAIL abort_rd got %0b exp 0", mem_rd_out); else passes++;
         end
         abort_in = (k == 18);
      end
      abort_in = 1'b0;
      checks++; if (np !== 0) $display("FAIL abort_pulses got %0d exp 0", np); else passes++;
      checks++; if (min_node_out !== 7'd37) $display("FAIL abort_node got %0d exp 37", min_node_out); else passes++;
      checks++; if (min_cost_out !== 8'd5) $display("FAIL abort_cost got %0d exp 5", min_cost_out); else passes++;
   endtask
`endif

   initial begin
      test_reset();
      test_single_open();
      test_none_open();
      test_ties();
      test_closed_mask();
      test_boundaries();
      test_start_ignored();
      test_rst_mid();
      test_back_to_back();
`ifdef BUSCA_MENOR_ABORT_EN
      test_abort();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
